// File: rtl/noc_vc_rx_buffer_pkg.sv
// Shared defaults and flit helpers for the VC receive buffer.
package noc_vc_rx_buffer_pkg;

  localparam int unsigned DEFAULT_VC_W = 2;
  localparam int unsigned DEFAULT_A_W  = 4;
  localparam int unsigned DEFAULT_D_W  = 8;

  // Flattened flit is {last, addr, data}.
  function automatic int unsigned flit_w(input int unsigned a_w, input int unsigned d_w);
    return a_w + d_w + 1;
  endfunction

endpackage

// File: rtl/noc_if.sv
// Credit-based NoC link: one-hot VC push strobe, packet, and per-VC credit return.
interface noc_if
  import noc_vc_rx_buffer_pkg::*;
#(
  parameter int unsigned VC_W = DEFAULT_VC_W,
  parameter int unsigned A_W  = DEFAULT_A_W,
  parameter int unsigned D_W  = DEFAULT_D_W
);

  typedef struct packed {
    logic [A_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
  } payload_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  logic [VC_W-1:0] vc_target;
  packet_t         packet;
  logic [VC_W-1:0] vc_credit_gnt;

  modport transmitter (output vc_target, output packet, input vc_credit_gnt);
  modport receiver (input vc_target, input packet, output vc_credit_gnt);

endinterface

// File: rtl/noc_vc_fifo.sv
// First-word-fall-through FIFO for one virtual channel. Push to a full FIFO is ignored;
// full is judged on the count before any same-cycle pop.
module noc_vc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PW+1)'(1);
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/noc_vc_rx_buffer.sv
// Receive endpoint of a credit-based link: per-VC FIFOs, packet-locked round-robin merge
// onto one valid/ready stream, and one registered credit pulse per flit drained.
module noc_vc_rx_buffer
  import noc_vc_rx_buffer_pkg::*;
#(
  parameter int unsigned VC_W       = DEFAULT_VC_W,
  parameter int unsigned A_W        = DEFAULT_A_W,
  parameter int unsigned D_W        = DEFAULT_D_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  noc_if.receiver         from_tx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VC_W-1:0] out_vc,
  output logic [A_W-1:0]  out_addr,
  output logic [D_W-1:0]  out_data,
  output logic            out_last,
  output logic            overflow_err
);

  localparam int unsigned FLIT_W = flit_w(A_W, D_W);
  localparam int unsigned IDX_W  = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [FLIT_W-1:0] wdata;
  logic [FLIT_W-1:0] rdata [VC_W];
  logic [CNT_W-1:0]  count [VC_W];
  logic [VC_W-1:0]   empty, full, pop;

  logic [IDX_W-1:0]  rr_q, lock_vc_q, held_vc_q, sel_idx, rr_next;
  logic              lock_q, held_q, sel_found, hs, overflow_q;
  logic [VC_W-1:0]   grant_q;

  assign wdata = {from_tx.packet.payload.last, from_tx.packet.routeinfo.addr,
                  from_tx.packet.payload.data};

  for (genvar v = 0; v < VC_W; v++) begin : g_fifo
    noc_vc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FLIT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (from_tx.vc_target[v]),
      .pop   (pop[v]),
      .wdata (wdata),
      .rdata (rdata[v]),
      .empty (empty[v]),
      .full  (full[v]),
      .count (count[v])
    );

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count[v] <= CNT_W'(FIFO_DEPTH));
  end

  // VC selection: locked packet first, then a stalled offer is held, else round robin.
  always_comb begin
    int cand;
    cand      = 0;
    sel_idx   = lock_vc_q;
    sel_found = 1'b0;
    if (lock_q) begin
      sel_idx   = lock_vc_q;
      sel_found = !empty[lock_vc_q];
    end else if (held_q) begin
      // Keeps out_* stable if a higher-priority VC fills while the consumer stalls.
      sel_idx   = held_vc_q;
      sel_found = !empty[held_vc_q];
    end else begin
      for (int i = 0; i < int'(VC_W); i++) begin
        cand = (int'(rr_q) + i) % int'(VC_W);
        if (!sel_found && !empty[cand]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Output presentation, handshake and pop decode.
  always_comb begin
    out_valid                      = sel_found;
    {out_last, out_addr, out_data} = rdata[sel_idx];
    out_vc                         = VC_W'(1) << sel_idx;
    hs                             = out_valid && out_ready;
    pop                            = hs ? out_vc : '0;
    rr_next                        = (sel_idx == IDX_W'(VC_W - 1)) ? '0 : sel_idx + IDX_W'(1);
  end

  // Arbiter state, credit pulse and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_vc_q  <= '0;
      held_q     <= 1'b0;
      held_vc_q  <= '0;
      grant_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      grant_q    <= pop;
      overflow_q <= overflow_q || (|(from_tx.vc_target & full));
      held_q     <= out_valid && !out_ready;
      held_vc_q  <= sel_idx;
      if (hs) begin
        rr_q      <= rr_next;
        lock_q    <= !out_last;
        lock_vc_q <= sel_idx;
      end
    end
  end

  assign from_tx.vc_credit_gnt = grant_q;
  assign overflow_err          = overflow_q;

  a_onehot_push: assert property (@(posedge clk) disable iff (rst)
    $onehot0(from_tx.vc_target));

  a_stable_out: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid &&
      $stable({out_vc, out_addr, out_data, out_last})));

endmodule

// File: tb/tb_noc_vc_rx_buffer.sv
// Directed bench for noc_vc_rx_buffer: reset, single flit, fill/drain, round robin,
// packet lock, overflow and mid-stream reset.
module tb_noc_vc_rx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, overflow_err;
  logic [1:0] out_vc;
  logic [3:0] out_addr;
  logic [7:0] out_data;

  int n_vec  = 0;
  int n_miss = 0;

  noc_if #(.VC_W(2), .A_W(4), .D_W(8)) link ();

  noc_vc_rx_buffer #(
    .VC_W       (2),
    .A_W        (4),
    .D_W        (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .from_tx      (link),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vc       (out_vc),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_last     (out_last),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int vc, input logic [3:0] addr, input logic [7:0] data,
                       input logic last);
    link.vc_target                 = 2'b01 << vc;
    link.packet.routeinfo.addr     = addr;
    link.packet.payload.data       = data;
    link.packet.payload.last       = last;
  endtask

  task automatic push(input int vc, input logic [3:0] addr, input logic [7:0] data,
                      input logic last);
    drive(vc, addr, data, last);
    tick();
    link.vc_target = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {29'd0, out_valid, link.vc_credit_gnt}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow_err}, 32'd0);
  endtask

  initial begin
    link.vc_target = '0;
    link.packet    = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset, idle
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("idle");
    end

    // Single flit on VC1
    out_ready = 1'b1;
    push(1, 4'd3, 8'hA5, 1'b1);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_vc", {30'd0, out_vc}, 32'd2);
    chk("t2_data", {24'd0, out_data}, 32'hA5);
    chk("t2_addr", {28'd0, out_addr}, 32'd3);
    chk("t2_last", {31'd0, out_last}, 32'd1);
    chk("t2_gnt0", {30'd0, link.vc_credit_gnt}, 32'd0);
    tick();
    chk("t2_gnt", {30'd0, link.vc_credit_gnt}, 32'd2);
    chk("t2_empty", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t2_gnt_end", {30'd0, link.vc_credit_gnt}, 32'd0);

    // Fill VC0 under backpressure, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(0, 4'(i), 8'(8'h10 + i), 1'b1);
      chk("t3_nogrant", {30'd0, link.vc_credit_gnt}, 32'd0);
    end
    chk("t3_held_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_held_data", {24'd0, out_data}, 32'h10);
    tick();
    chk("t3_held_data2", {24'd0, out_data}, 32'h10);
    chk("t3_nogrant2", {30'd0, link.vc_credit_gnt}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", {24'd0, out_data}, 32'h10 + i);
      chk("t3_addr", {28'd0, out_addr}, i);
      chk("t3_vc", {30'd0, out_vc}, 32'd1);
      tick();
      chk("t3_gnt", {30'd0, link.vc_credit_gnt}, 32'd1);
    end
    chk("t3_drained", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t3_gnt_end", {30'd0, link.vc_credit_gnt}, 32'd0);

    // Round robin between VC0 and VC1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 4'd0, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 3; i++) push(1, 4'd1, 8'(8'h30 + i), 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] ev;
      logic [7:0] ed;
      ev = (i % 2 == 0) ? 2'b01 : 2'b10;
      ed = (i % 2 == 0) ? 8'(8'h20 + i / 2) : 8'(8'h30 + i / 2);
      chk("t4_vc", {30'd0, out_vc}, {30'd0, ev});
      chk("t4_data", {24'd0, out_data}, {24'd0, ed});
      tick();
      chk("t4_gnt", {30'd0, link.vc_credit_gnt}, {30'd0, ev});
    end
    chk("t4_drained", {31'd0, out_valid}, 32'd0);

    // Packet lock on VC0 while VC1 waits
    out_ready = 1'b0;
    push(0, 4'd5, 8'h40, 1'b0);
    push(1, 4'd6, 8'h50, 1'b1);
    out_ready = 1'b1;
    chk("t5_vc_a", {30'd0, out_vc}, 32'd1);
    chk("t5_data_a", {24'd0, out_data}, 32'h40);
    chk("t5_last_a", {31'd0, out_last}, 32'd0);
    tick();
    chk("t5_gnt_a", {30'd0, link.vc_credit_gnt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_locked_idle", {31'd0, out_valid}, 32'd0);
      tick();
    end
    push(0, 4'd5, 8'h41, 1'b0);
    chk("t5_valid_b", {31'd0, out_valid}, 32'd1);
    chk("t5_vc_b", {30'd0, out_vc}, 32'd1);
    chk("t5_data_b", {24'd0, out_data}, 32'h41);
    tick();
    chk("t5_locked_idle2", {31'd0, out_valid}, 32'd0);
    push(0, 4'd5, 8'h42, 1'b1);
    chk("t5_vc_c", {30'd0, out_vc}, 32'd1);
    chk("t5_data_c", {24'd0, out_data}, 32'h42);
    chk("t5_last_c", {31'd0, out_last}, 32'd1);
    tick();
    chk("t5_vc_x", {30'd0, out_vc}, 32'd2);
    chk("t5_data_x", {24'd0, out_data}, 32'h50);
    chk("t5_valid_x", {31'd0, out_valid}, 32'd1);
    tick();
    chk("t5_drained", {31'd0, out_valid}, 32'd0);

    // Overflow: fifth push dropped, even with a same-cycle pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 4'd7, 8'(8'h60 + i), 1'b1);
    chk("t6_ovf_clear", {31'd0, overflow_err}, 32'd0);
    push(0, 4'd15, 8'h6F, 1'b1);
    chk("t6_ovf_set", {31'd0, overflow_err}, 32'd1);
    chk("t6_head", {24'd0, out_data}, 32'h60);
    drive(0, 4'd7, 8'h70, 1'b1);
    out_ready = 1'b1;
    chk("t6_data0", {24'd0, out_data}, 32'h60);
    tick();
    link.vc_target = '0;
    for (int i = 1; i < 4; i++) begin
      chk("t6_data", {24'd0, out_data}, 32'h60 + i);
      tick();
    end
    chk("t6_drained", {31'd0, out_valid}, 32'd0);
    chk("t6_ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // Reset mid-stream discards flits and clears the flag
    out_ready = 1'b0;
    push(1, 4'd1, 8'h80, 1'b1);
    push(1, 4'd2, 8'h81, 1'b1);
    chk("t6_pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pre_rst_vc", {30'd0, out_vc}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("t6_post_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("t6_post_rst_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
